// File: rtl/m_store_buf.sv
// Store buffer: queues M-stage stores and retires them in order to the DM write port
// whenever a load is not using it. Optional STORE_ALIGN_CHECK_EN rejects misaligned w/h stores.
module m_store_buf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_pc,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_op,
  output logic             st_ready,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             dm_idle,
  output logic             dm_we,
  output logic [31:0]      dm_pc,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [3:0]       dm_op,
  input  logic             drain_req,
`ifdef STORE_ALIGN_CHECK_EN
  output logic             st_misalign,
`endif
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [3:0] MEMOP_NOPE = 4'h0;
  localparam logic [3:0] MEMOP_W    = 4'h1;
  localparam logic [3:0] MEMOP_H    = 4'h2;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       op_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   cnt_q;

  logic full, is_empty, accept, push, pop, hit;

  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign is_empty = (cnt_q == '0);
  assign st_ready = !full && !drain_req;
  assign accept   = st_valid && st_ready && (st_op != MEMOP_NOPE);

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned, misalign_q;
  assign misaligned = ((st_op == MEMOP_W) && (st_addr[1:0] != 2'b00)) ||
                      ((st_op == MEMOP_H) && st_addr[0]);
  assign push        = accept && !misaligned;
  assign st_misalign = misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= accept && misaligned;
  end
`else
  assign push = accept;
`endif

  assign pop   = !is_empty && dm_idle;
  assign dm_we = pop;
  assign empty = is_empty;
  assign count = cnt_q;

  // Head is only meaningful when occupied; show zeros otherwise.
  assign dm_pc   = is_empty ? 32'h0 : pc_q[head_q];
  assign dm_addr = is_empty ? 32'h0 : addr_q[head_q];
  assign dm_wd   = is_empty ? 32'h0 : data_q[head_q];
  assign dm_op   = is_empty ? MEMOP_NOPE : op_q[head_q];

  // Word-granular match against every pending store, regardless of access size.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) hit = 1'b1;
    end
  end
  assign ld_stall = ld_req && hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= 32'h0;
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
        op_q[i]   <= MEMOP_NOPE;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        pc_q[tail_q]    <= st_pc;
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        op_q[tail_q]    <= st_op;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_m_store_buf.sv
// Directed table-driven bench for m_store_buf, plus an ordering scoreboard run
// and, when STORE_ALIGN_CHECK_EN is defined, a misalignment sequence.
module tb_m_store_buf;

  localparam logic [3:0] NOPE = 4'h0;
  localparam logic [3:0] W    = 4'h1;
  localparam logic [3:0] H    = 4'h2;
  localparam logic [3:0] B    = 4'h3;

  logic        clk, reset;
  logic        st_valid, st_ready, ld_req, ld_stall, dm_idle, dm_we, drain_req, empty;
  logic [31:0] st_pc, st_addr, st_data, ld_addr, dm_pc, dm_addr, dm_wd;
  logic [3:0]  st_op, dm_op;
  logic [2:0]  count;
`ifdef STORE_ALIGN_CHECK_EN
  logic        st_misalign;
`endif

  m_store_buf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data),
    .st_op(st_op), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .dm_idle(dm_idle), .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr),
    .dm_wd(dm_wd), .dm_op(dm_op), .drain_req(drain_req),
`ifdef STORE_ALIGN_CHECK_EN
    .st_misalign(st_misalign),
`endif
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, sv;
    logic [31:0] sa, sd;
    logic [3:0]  so;
    logic        lr;
    logic [31:0] la;
    logic        idle, drn;
    logic        e_rdy, e_stall, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_op;
    logic        e_empty;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst_n, sv, input logic [31:0] sa, sd, input logic [3:0] so,
                     input logic lr, input logic [31:0] la, input logic idle, drn,
                     input logic e_rdy, e_stall, e_we, input logic [31:0] e_addr, e_wd,
                     input logic [3:0] e_op, input logic e_empty, input logic [2:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.sv = sv; v.sa = sa; v.sd = sd; v.so = so; v.lr = lr; v.la = la;
    v.idle = idle; v.drn = drn; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_op = e_op; v.e_empty = e_empty; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; st_valid = 0; st_pc = 0; st_addr = 0; st_data = 0; st_op = NOPE;
    ld_req = 0; ld_addr = 0; dm_idle = 0; drain_req = 0;

    //    rst sv addr      data          op   lr la      idl drn | rdy stl we addr      wd            op   emp cnt
    add(0, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 0 reset
    add(0, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h10, 32'hDEADBEEF, W,    0, 32'h0,  1, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 3 single sw, no bypass
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 1, 32'h10, 32'hDEADBEEF, W,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h0,  32'hA0,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 6 fill
    add(1, 1, 32'h4,  32'hA1,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'hA0,       W,    0, 1);
    add(1, 1, 32'h8,  32'hA2,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'hA0,       W,    0, 2);
    add(1, 1, 32'hC,  32'hA3,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'hA0,       W,    0, 3);
    add(1, 1, 32'h20, 32'hA4,       W,    0, 32'h0,  0, 0,   0, 0, 0, 32'h0,  32'hA0,       W,    0, 4); // 10 full
    add(1, 1, 32'h20, 32'hA4,       W,    0, 32'h0,  1, 0,   0, 0, 1, 32'h0,  32'hA0,       W,    0, 4); // full + pop: refused
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 1, 32'h4,  32'hA1,       W,    0, 3);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 1, 32'h8,  32'hA2,       W,    0, 2);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 1, 32'hC,  32'hA3,       W,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h30, 32'hB0,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 16 push+pop
    add(1, 1, 32'h34, 32'hB1,       W,    0, 32'h0,  1, 0,   1, 0, 1, 32'h30, 32'hB0,       W,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 1, 32'h34, 32'hB1,       W,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h40, 32'hCC,       NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 20 nope consumed
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h13, 32'h55,       B,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 22 load hazard
    add(1, 0, 32'h0,  32'h0,        NOPE, 1, 32'h10, 0, 0,   1, 1, 0, 32'h13, 32'h55,       B,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 1, 32'h14, 0, 0,   1, 0, 0, 32'h13, 32'h55,       B,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h10, 0, 0,   1, 0, 0, 32'h13, 32'h55,       B,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 1, 32'h10, 1, 0,   1, 1, 1, 32'h13, 32'h55,       B,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 1, 32'h10, 0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h50, 32'hC0,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 28 drain
    add(1, 1, 32'h54, 32'hC1,       H,    0, 32'h0,  0, 0,   1, 0, 0, 32'h50, 32'hC0,       W,    0, 1);
    add(1, 1, 32'h58, 32'hC2,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h50, 32'hC0,       W,    0, 2);
    add(1, 1, 32'h60, 32'hC3,       W,    0, 32'h0,  0, 1,   0, 0, 0, 32'h50, 32'hC0,       W,    0, 3);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 1, 32'h50, 32'hC0,       W,    0, 3);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 1, 32'h54, 32'hC1,       H,    0, 2);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 1, 32'h58, 32'hC2,       W,    0, 1);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 1, 32'h70, 32'hD0,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0); // 37 drain + reset
    add(1, 1, 32'h74, 32'hD1,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h70, 32'hD0,       W,    0, 1);
    add(1, 1, 32'h78, 32'hD2,       W,    0, 32'h0,  0, 0,   1, 0, 0, 32'h70, 32'hD0,       W,    0, 2);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 1, 32'h70, 32'hD0,       W,    0, 3);
    add(0, 0, 32'h0,  32'h0,        NOPE, 1, 32'h74, 1, 1,   0, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 1,   0, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);
    add(1, 0, 32'h0,  32'h0,        NOPE, 0, 32'h0,  1, 0,   1, 0, 0, 32'h0,  32'h0,        NOPE, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst_n; st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_data = vecs[i].sd;
      st_pc = vecs[i].sa + 32'h1000; st_op = vecs[i].so; ld_req = vecs[i].lr;
      ld_addr = vecs[i].la; dm_idle = vecs[i].idle; drain_req = vecs[i].drn;
      @(negedge clk);
      check("st_ready", i, 32'(st_ready), 32'(vecs[i].e_rdy));
      check("ld_stall", i, 32'(ld_stall), 32'(vecs[i].e_stall));
      check("dm_we",    i, 32'(dm_we),    32'(vecs[i].e_we));
      check("dm_addr",  i, dm_addr,       vecs[i].e_addr);
      check("dm_wd",    i, dm_wd,         vecs[i].e_wd);
      check("dm_op",    i, 32'(dm_op),    32'(vecs[i].e_op));
      check("dm_pc",    i, dm_pc,         vecs[i].e_empty ? 32'h0 : vecs[i].e_addr + 32'h1000);
      check("empty",    i, 32'(empty),    32'(vecs[i].e_empty));
      check("count",    i, 32'(count),    32'(vecs[i].e_cnt));
    end

    // Ordering scoreboard: continuous store pressure with an intermittent DM port.
    begin
      logic [31:0] q[$];
      logic        exp_rdy, exp_we;
      for (int i = 0; i < 28; i++) begin
        @(posedge clk); #1;
        st_valid = (i < 20); st_op = W; st_addr = 32'h100 + 32'(i) * 4; st_data = 32'(i);
        st_pc = st_addr + 32'h1000; ld_req = 0; drain_req = 0; dm_idle = (i % 3 != 0);
        @(negedge clk);
        exp_rdy = (q.size() < 4);
        exp_we  = (q.size() > 0) && dm_idle;
        check("sb.st_ready", i, 32'(st_ready), 32'(exp_rdy));
        check("sb.dm_we",    i, 32'(dm_we),    32'(exp_we));
        check("sb.count",    i, 32'(count),    32'(q.size()));
        if (exp_we) begin
          check("sb.dm_addr", i, dm_addr, q[0]);
          check("sb.dm_wd",   i, dm_wd,   (q[0] - 32'h100) >> 2);
          void'(q.pop_front());
        end
        if (st_valid && exp_rdy) q.push_back(st_addr);
      end
      @(posedge clk); #1;
      st_valid = 0; dm_idle = 0;
      @(negedge clk);
      check("sb.final_count", 0, 32'(count), 32'(q.size()));
      check("sb.final_empty", 0, 32'(empty), 32'(q.size() == 0));
    end

`ifdef STORE_ALIGN_CHECK_EN
    @(posedge clk); #1;
    st_valid = 1; st_op = W; st_addr = 32'h2; st_data = 32'h77; dm_idle = 0;
    @(negedge clk);
    check("al.sw_ready", 0, 32'(st_ready), 32'h1);
    check("al.pre_flag", 0, 32'(st_misalign), 32'h0);
    @(posedge clk); #1; st_valid = 0;
    @(negedge clk);
    check("al.flag_hi", 1, 32'(st_misalign), 32'h1);
    check("al.sw_count", 1, 32'(count), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("al.flag_lo", 2, 32'(st_misalign), 32'h0);
    @(posedge clk); #1; st_valid = 1; st_op = H; st_addr = 32'h2;
    @(negedge clk);
    check("al.sh_ready", 3, 32'(st_ready), 32'h1);
    @(posedge clk); #1; st_valid = 0;
    @(negedge clk);
    check("al.sh_flag", 4, 32'(st_misalign), 32'h0);
    check("al.sh_count", 4, 32'(count), 32'h1);
    check("al.sh_addr", 4, dm_addr, 32'h2);
    @(posedge clk); #1; dm_idle = 1;
    @(negedge clk);
    check("al.sh_we", 5, 32'(dm_we), 32'h1);
    @(posedge clk); #1; dm_idle = 0;
    @(negedge clk);
    check("al.empty", 6, 32'(empty), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
